// File: rtl/cmp_seq_pkg.sv
// Shared definitions for the nibble-serial compare sequencer: FSM state
// encoding and the parameter derivations used by cmp_seq.
package cmp_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of 4-bit nibbles in an operand of the given width.
  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  // Nibble index width: clog2 of the nibble count, never narrower than 1 bit.
  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/comp4b.sv
// Combinational 4-bit unsigned magnitude comparator; the single nibble
// datapath shared by every step of the sequencer.
module comp4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_seq.sv
// Multi-word compare engine: walks two latched operands one nibble per clock
// from the MSB end through comp4b, stopping at the first unequal nibble.
module cmp_seq
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NIB = nib_count(WIDTH);
  localparam int IW  = idx_w(NIB);
  localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

  state_t           state, state_d;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [3:0]       nib_a, nib_b;
  logic             c_gt, c_lt, c_eq;
  logic             load, finish;

  // Nibble mux plus offset-binary flip of the sign nibble in signed mode,
  // which turns a two's complement compare into an unsigned one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_q[i*4 +: 4];
        nib_b = b_q[i*4 +: 4];
      end
    end
    if (sgn_q && (idx == IDX_TOP)) begin
      nib_a[3] = ~nib_a[3];
      nib_b[3] = ~nib_b[3];
    end
  end

  comp4b u_comp4b (
    .a  (nib_a),
    .b  (nib_b),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!c_eq || (idx == '0)) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      done  <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_d;
      done  <= finish;
      if (load) begin
        idx <= IDX_TOP;
      end else if ((state == ST_RUN) && !finish) begin
        idx <= idx - IW'(1);
      end
      if (finish) begin
        gt <= c_gt;
        lt <= c_lt;
        eq <= c_eq;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only read in RUN, which is always entered through a load.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= signed_mode;
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq: directed vectors plus a cycle-level
// reference model compared against the DUT outputs on every clock.
module tb_cmp_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, gt, lt, eq;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  cmp_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .lt          (lt),
    .eq          (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of the comparison straight from integer arithmetic: {gt,lt,eq}.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b010;
      return 3'b001;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from the start edge to done: one plus the leading equal nibbles.
  function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
    int k = 1;
    for (int i = NIB - 1; i > 0; i--) begin
      if (x[i*4 +: 4] != y[i*4 +: 4]) return k;
      k++;
    end
    return k;
  endfunction

  // Reference model: a countdown of the predicted latency and the pending result.
  logic       m_busy = 1'b0, m_done = 1'b0, m_gt = 1'b0, m_lt = 1'b0, m_eq = 1'b0;
  int         m_left = 0;
  logic [2:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_gt   <= 1'b0;
      m_lt   <= 1'b0;
      m_eq   <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_gt, m_lt, m_eq} <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= lat_of(a, b);
        m_pend <= ref_cmp(a, b, signed_mode);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs {busy,done,gt,lt,eq}", {busy, done, gt, lt, eq},
            {m_busy, m_done, m_gt, m_lt, m_eq});
      if (done === 1'b1) check("one-hot result at done", $countones({gt, lt, eq}), 1);
    end
  end

  // Issue one compare, then measure latency and result; busy must stay high until done.
  task automatic run_cmp(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, input logic [2:0] exp_res, input int exp_lat);
    int lat = 0;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; signed_mode = sm;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); signed_mode = ~sm;
    for (int c = 1; c <= NIB + 2 && lat == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) lat = c;
      else check({name, " busy while running"}, busy, 1'b1);
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result {gt,lt,eq}"}, {gt, lt, eq}, exp_res);
    check({name, " busy low at done"}, busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb, mask;
    logic         rs;
    int           keep;

    // Model pinned to hand-computed values
    check("model 1234=1234 u", ref_cmp(16'h1234, 16'h1234, 1'b0), 3'b001);
    check("model 8000>7fff u", ref_cmp(16'h8000, 16'h7FFF, 1'b0), 3'b100);
    check("model 8000<7fff s", ref_cmp(16'h8000, 16'h7FFF, 1'b1), 3'b010);
    check("model fffe<ffff s", ref_cmp(16'hFFFE, 16'hFFFF, 1'b1), 3'b010);
    check("model lat 12a4/12b4", lat_of(16'h12A4, 16'h12B4), 3);
    check("model lat 1234/1234", lat_of(16'h1234, 16'h1234), 4);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset state", {busy, done, gt, lt, eq}, 5'b00000);

    run_cmp("t1 equal", 16'h1234, 16'h1234, 1'b0, 3'b001, 4);
    run_cmp("t2 unsigned msb", 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1);
    run_cmp("t2 signed msb", 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1);
    run_cmp("t3 unsigned mid", 16'h12A4, 16'h12B4, 1'b0, 3'b010, 3);
    run_cmp("t3 signed neg", 16'hFFFE, 16'hFFFF, 1'b1, 3'b010, 4);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; a = 16'h0001; b = 16'h0002; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hF000; b = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t4 still busy at cycle 3", {busy, done}, 2'b10);
    @(negedge clk);
    check("t4 done at cycle 4", {busy, done}, 2'b01);
    check("t4 result ignores busy start", {gt, lt, eq}, 3'b010);
    start = 1'b1; a = 16'h5000; b = 16'h4000;
    @(negedge clk);
    start = 1'b0;
    check("t4 back-to-back accepted", {busy, done}, 2'b10);
    @(negedge clk);
    check("t4 back-to-back done", {busy, done}, 2'b01);
    check("t4 back-to-back result", {gt, lt, eq}, 3'b100);

    // Reset mid-run aborts with no done and cleared results.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 after reset", {busy, done, gt, lt, eq}, 5'b00000);
    repeat (4) begin
      @(negedge clk);
      check("t5 no done after abort", done, 1'b0);
    end
    run_cmp("t5 zero equal", 16'h0000, 16'h0000, 1'b0, 3'b001, 4);

    // Random operands sharing a random number of leading nibbles.
    for (int n = 0; n < 300; n++) begin
      ra   = W'($urandom);
      keep = $urandom_range(0, NIB);
      mask = (keep == 0) ? '0 : ~(W'({W{1'b1}}) >> (4 * keep));
      rb   = (ra & mask) | (W'($urandom) & ~mask);
      rs   = 1'($urandom_range(0, 1));
      run_cmp("random", ra, rb, rs, ref_cmp(ra, rb, rs), lat_of(ra, rb));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
